// File: rtl/fc_pkg.sv
// Shared types, widths and the requantiser for the FC layer engine.
package fc_pkg;

    localparam int FC_DATA_WIDTH     = 8;
    localparam int FC_WEIGHT_WIDTH   = 4;
    localparam int FC_LANES          = 20;
    localparam int FC_ACC_WIDTH      = 24;
    localparam int FC_ACT_ADDR_WIDTH = 6;
    localparam int FC_W_ADDR_WIDTH   = 15;
    localparam int FC_OUT_ADDR_WIDTH = 6;
    localparam int FC_SHIFT_WIDTH    = 5;

    localparam int PROD_WIDTH = FC_DATA_WIDTH + FC_WEIGHT_WIDTH;
    localparam int SAT_MAX    = (1 << (FC_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN    = -(1 << (FC_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_e;

    // Round-half-up arithmetic shift, optional ReLU, then saturate to DATA_WIDTH.
    // A 64-bit intermediate keeps the rounding constant and the sum exact for
    // every shift amount the SHIFT_WIDTH field can express.
    function automatic logic signed [FC_DATA_WIDTH-1:0] sat_q(
        input logic signed [FC_ACC_WIDTH-1:0]   acc,
        input logic        [FC_SHIFT_WIDTH-1:0] shift,
        input logic                             relu
    );
        logic signed [63:0] v;
        v = 64'(acc);
        if (shift != '0) begin
            v = (v + (64'sd1 <<< (shift - FC_SHIFT_WIDTH'(1)))) >>> shift;
        end
        if (relu && (v < 64'sd0)) begin
            v = 64'sd0;
        end
        if (v > 64'(SAT_MAX)) begin
            v = 64'(SAT_MAX);
        end else if (v < 64'(SAT_MIN)) begin
            v = 64'(SAT_MIN);
        end
        return FC_DATA_WIDTH'(v);
    endfunction

endpackage

// File: rtl/fc_dot_lanes.sv
// Combinational LANES-wide signed dot product of one activation word and one weight word.
module fc_dot_lanes
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = FC_WEIGHT_WIDTH,
    parameter int LANES        = FC_LANES,
    parameter int ACC_WIDTH    = FC_ACC_WIDTH
) (
    input  logic [LANES*DATA_WIDTH-1:0]   i_act,
    input  logic [LANES*WEIGHT_WIDTH-1:0] i_wgt,
    output logic signed [ACC_WIDTH-1:0]   o_sum
);

    localparam int P_W = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [P_W-1:0] w_prod [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_prod[gi] = P_W'($signed(i_act[gi*DATA_WIDTH +: DATA_WIDTH]))
                          * P_W'($signed(i_wgt[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    end

    // Sum of all sign-extended lane products; synthesis balances it into a tree.
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            o_sum = o_sum + ACC_WIDTH'(w_prod[i]);
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// One fully-connected layer per start pulse: streams packed activation/weight
// words, accumulates LANES MACs per cycle and writes one requantised output per neuron.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | waiting for start; cfg_* latched on the start cycle
//  ST_RUN   | one activation/weight read pair per cycle, no bubbles
//  ST_DRAIN | read data and final write still in flight (2 cycles)
//  ST_DONE  | done pulse; start is ignored here
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH     = FC_DATA_WIDTH,
    parameter int WEIGHT_WIDTH   = FC_WEIGHT_WIDTH,
    parameter int LANES          = FC_LANES,
    parameter int ACC_WIDTH      = FC_ACC_WIDTH,
    parameter int ACT_ADDR_WIDTH = FC_ACT_ADDR_WIDTH,
    parameter int W_ADDR_WIDTH   = FC_W_ADDR_WIDTH,
    parameter int OUT_ADDR_WIDTH = FC_OUT_ADDR_WIDTH,
    parameter int SHIFT_WIDTH    = FC_SHIFT_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_srstn,
    input  logic                             i_start,
    input  logic [ACT_ADDR_WIDTH-1:0]        i_cfg_in_words,
    input  logic [OUT_ADDR_WIDTH-1:0]        i_cfg_out_num,
    input  logic [W_ADDR_WIDTH-1:0]          i_cfg_w_base,
    input  logic [SHIFT_WIDTH-1:0]           i_cfg_shift,
    input  logic                             i_cfg_relu,
    output logic [ACT_ADDR_WIDTH-1:0]        o_act_raddr,
    input  logic [LANES*DATA_WIDTH-1:0]      i_act_rdata,
    output logic [W_ADDR_WIDTH-1:0]          o_w_raddr,
    input  logic [LANES*WEIGHT_WIDTH-1:0]    i_w_rdata,
    output logic                             o_out_we,
    output logic [OUT_ADDR_WIDTH-1:0]        o_out_waddr,
    output logic [DATA_WIDTH-1:0]            o_out_wdata,
    output logic                             o_busy,
    output logic                             o_done
);

    // Second DRAIN cycle is the one whose end registers the last write.
    localparam logic DRAIN_LOAD = 1'b1;

    fc_state_e r_state;
    fc_state_e w_state_next;

    logic [ACT_ADDR_WIDTH-1:0] r_in_words;
    logic [OUT_ADDR_WIDTH-1:0] r_out_num;
    logic [SHIFT_WIDTH-1:0]    r_shift;
    logic                      r_relu;
    logic                      r_empty;

    logic [ACT_ADDR_WIDTH-1:0] r_k;
    logic [OUT_ADDR_WIDTH-1:0] r_j;
    logic [W_ADDR_WIDTH-1:0]   r_waddr;
    logic                      r_drain_cnt;

    logic                      r_p_vld;
    logic                      r_p_first;
    logic                      r_p_last;
    logic [OUT_ADDR_WIDTH-1:0] r_p_j;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_dot;
    logic signed [ACC_WIDTH-1:0] w_acc_next;

    logic w_accept;
    logic w_issue;
    logic w_k_last;
    logic w_j_last;

    assign w_k_last    = (r_k == r_in_words - ACT_ADDR_WIDTH'(1));
    assign w_j_last    = (r_j == r_out_num - OUT_ADDR_WIDTH'(1));
    assign w_acc_next  = r_p_first ? w_dot : (r_acc + w_dot);
    assign o_act_raddr = r_k;
    assign o_w_raddr   = r_waddr;

    fc_dot_lanes #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .LANES        (LANES),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_dot (
        .i_act (i_act_rdata),
        .i_wgt (i_w_rdata),
        .o_sum (w_dot)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (r_empty) begin
                    w_state_next = ST_DONE;
                end else if (w_k_last && w_j_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: if (r_drain_cnt == 1'b0) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: accept/issue strobes and status flags.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && i_start;
        w_issue  = (r_state == ST_RUN) && !r_empty;
        o_busy   = (r_state != ST_IDLE);
        o_done   = (r_state == ST_DONE);
    end

    // Drain down-counter, reloaded every RUN cycle and counted out in DRAIN.
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            r_drain_cnt <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_drain_cnt <= DRAIN_LOAD;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    // Config latch and read-address counters; weight address is a running count.
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            r_in_words <= '0;
            r_out_num  <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_empty    <= 1'b0;
            r_k        <= '0;
            r_j        <= '0;
            r_waddr    <= '0;
        end else if (w_accept) begin
            r_in_words <= i_cfg_in_words;
            r_out_num  <= i_cfg_out_num;
            r_shift    <= i_cfg_shift;
            r_relu     <= i_cfg_relu;
            r_empty    <= (i_cfg_in_words == '0) || (i_cfg_out_num == '0);
            r_k        <= '0;
            r_j        <= '0;
            r_waddr    <= i_cfg_w_base;
        end else if (w_issue) begin
            r_waddr <= r_waddr + W_ADDR_WIDTH'(1);
            if (w_k_last) begin
                r_k <= '0;
                r_j <= r_j + OUT_ADDR_WIDTH'(1);
            end else begin
                r_k <= r_k + ACT_ADDR_WIDTH'(1);
            end
        end
    end

    // Tags travelling alongside the read data (arrives one cycle after the address).
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            r_p_vld   <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_j     <= '0;
        end else begin
            r_p_vld   <= w_issue;
            r_p_first <= (r_k == '0);
            r_p_last  <= w_k_last;
            r_p_j     <= r_j;
        end
    end

    // Accumulator: loads on the first word of a neuron, adds otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            r_acc <= '0;
        end else if (r_p_vld) begin
            r_acc <= w_acc_next;
        end
    end

    // Registered requantise of the completed sum and the output write strobe.
    always_ff @(posedge i_clk) begin
        if (!i_srstn) begin
            o_out_we    <= 1'b0;
            o_out_waddr <= '0;
            o_out_wdata <= '0;
        end else begin
            o_out_we <= r_p_vld && r_p_last;
            if (r_p_vld && r_p_last) begin
                o_out_waddr <= r_p_j;
                o_out_wdata <= sat_q(w_acc_next, r_shift, r_relu);
            end
        end
    end

endmodule
